// File: rtl/lc3_pkg.sv
// ============================================================================
//  Module      : lc3_pkg
//  Description : Shared MAR source-select codes and MAR access FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

  localparam logic [1:0] MARSEL_ZEXT = 2'd0;
  localparam logic [1:0] MARSEL_ADDR = 2'd1;
  localparam logic [1:0] MARSEL_BUS  = 2'd2;
  localparam logic [1:0] MARSEL_INC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mar_state_t;

endpackage

`default_nettype wire

// File: rtl/mar_src_mux.sv
// ============================================================================
//  Module      : mar_src_mux
//  Description : Combinational 4:1 MAR source select with IR vector zero-extend.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mar_src_mux
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int VEC_W  = 8
) (
  input  logic [1:0]        i_MarSel,
  input  logic [VEC_W-1:0]  i_IR_Vec,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic [ADDR_W-1:0] i_Bus,
  input  logic [ADDR_W-1:0] i_Mar,
  output logic [ADDR_W-1:0] o_MarMux
);

  logic [ADDR_W-1:0] w_zext;

  always_comb begin
    w_zext              = '0;
    w_zext[VEC_W-1:0]   = i_IR_Vec;
  end

  // Increment wraps naturally at ADDR_W bits; no carry out is kept.
  always_comb begin
    o_MarMux = '0;
    case (i_MarSel)
      MARSEL_ZEXT: o_MarMux = w_zext;
      MARSEL_ADDR: o_MarMux = i_Address;
      MARSEL_BUS:  o_MarMux = i_Bus;
      MARSEL_INC:  o_MarMux = i_Mar + ADDR_W'(1);
      default:     o_MarMux = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mar_unit.sv
// ============================================================================
//  Module      : mar_unit
//  Description : MAR source select, MAR register and single-access memory
//                sequencer with ready handshake and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mar_unit
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int VEC_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_LdMar,
  input  logic [1:0]        i_MarSel,
  input  logic [VEC_W-1:0]  i_IR_Vec,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic [ADDR_W-1:0] i_Bus,
  input  logic              i_Start,
  input  logic              i_Write,
  input  logic              i_MemReady,
  output logic [ADDR_W-1:0] o_Mar,
  output logic [ADDR_W-1:0] o_MarMux,
  output logic              o_MemEn,
  output logic              o_MemWe,
  output logic              o_Busy,
  output logic              o_Ready,
  output logic              o_Timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

  mar_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] w_mux;
  logic              w_expire;

  mar_src_mux #(
    .ADDR_W (ADDR_W),
    .VEC_W  (VEC_W)
  ) u_src_mux (
    .i_MarSel  (i_MarSel),
    .i_IR_Vec  (i_IR_Vec),
    .i_Address (i_Address),
    .i_Bus     (i_Bus),
    .i_Mar     (mar_q),
    .o_MarMux  (w_mux)
  );

  assign w_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    mar_d     = mar_q;
    timeout_d = 1'b0;

    // MAR is frozen outside IDLE so the address is stable for the whole access.
    if (i_LdMar && (state_q == IDLE)) begin
      mar_d = w_mux;
    end

    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d = ACCESS;
          we_d    = i_Write;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (i_MemReady) begin
          state_d = DONE;
        end else if (w_expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    mem_en_d = (state_d == ACCESS);
    mem_we_d = (state_d == ACCESS) && we_d;
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == DONE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      mar_q     <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      mar_q     <= mar_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Mar     = mar_q;
  assign o_MarMux  = w_mux;
  assign o_MemEn   = mem_en_q;
  assign o_MemWe   = mem_we_q;
  assign o_Busy    = busy_q;
  assign o_Ready   = ready_q;
  assign o_Timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mar_unit.sv
// ============================================================================
//  Module      : tb_mar_unit
//  Description : Directed vector and sequence bench for mar_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mar_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_mar;
  logic [1:0]  mar_sel;
  logic [7:0]  ir_vec;
  logic [15:0] address;
  logic [15:0] bus;
  logic        start;
  logic        write;
  logic        mem_ready;
  logic [15:0] mar;
  logic [15:0] mar_mux;
  logic        mem_en;
  logic        mem_we;
  logic        busy;
  logic        ready;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mar_unit #(
    .ADDR_W  (16),
    .VEC_W   (8),
    .TIMEOUT (15)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_LdMar    (ld_mar),
    .i_MarSel   (mar_sel),
    .i_IR_Vec   (ir_vec),
    .i_Address  (address),
    .i_Bus      (bus),
    .i_Start    (start),
    .i_Write    (write),
    .i_MemReady (mem_ready),
    .o_Mar      (mar),
    .o_MarMux   (mar_mux),
    .o_MemEn    (mem_en),
    .o_MemWe    (mem_we),
    .o_Busy     (busy),
    .o_Ready    (ready),
    .o_Timeout  (timeout)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  vec;
    logic [15:0] addr;
    logic [15:0] bus;
    logic        ld;
    logic [15:0] exp_mux;
    logic [15:0] exp_mar;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] value);
    ld_mar  = 1'b1;
    mar_sel = 2'd2;
    bus     = value;
    tick();
    ld_mar  = 1'b0;
  endtask

  // Issue one access; MemReady is raised in the ready_after-th ACCESS cycle (0 = never).
  task automatic run_access(input int ready_after, input logic wr,
                            output int en_cycles, output int we_cycles,
                            output logic got_ready, output logic got_to);
    en_cycles = 0;
    we_cycles = 0;
    got_ready = 1'b0;
    got_to    = 1'b0;
    write     = wr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    write     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_en) begin
        en_cycles++;
        if (mem_we) we_cycles++;
        mem_ready = (en_cycles == ready_after);
      end else begin
        mem_ready = 1'b0;
      end
      if (ready) begin
        got_ready = 1'b1;
        got_to    = timeout;
        break;
      end
      tick();
    end
    mem_ready = 1'b0;
  endtask

  vec_t vt[8];
  int   en_n, we_n;
  logic rdy, to;

  initial begin
    rst = 1'b1; ld_mar = 1'b0; mar_sel = 2'd0; ir_vec = '0; address = '0;
    bus = '0; start = 1'b0; write = 1'b0; mem_ready = 1'b0;

    vt[0] = '{2'd0, 8'h25, 16'h0000, 16'h0000, 1'b1, 16'h0025, 16'h0025};
    vt[1] = '{2'd1, 8'h00, 16'h3000, 16'h0000, 1'b1, 16'h3000, 16'h3000};
    vt[2] = '{2'd2, 8'h00, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF};
    vt[3] = '{2'd3, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vt[4] = '{2'd3, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0001};
    vt[5] = '{2'd2, 8'h00, 16'h0000, 16'h1234, 1'b0, 16'h1234, 16'h0001};
    vt[6] = '{2'd3, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h0002, 16'h0002};
    vt[7] = '{2'd0, 8'hFF, 16'hABCD, 16'h5555, 1'b1, 16'h00FF, 16'h00FF};

    tick();
    tick();
    chk("reset_mar", mar, 16'h0000);
    chk("reset_outs", {mem_en, mem_we, busy, ready, timeout}, 5'b0);
    rst = 1'b0;
    tick();
    chk("idle_outs", {mem_en, mem_we, busy, ready, timeout}, 5'b0);

    foreach (vt[i]) begin
      mar_sel = vt[i].sel; ir_vec = vt[i].vec; address = vt[i].addr;
      bus = vt[i].bus; ld_mar = vt[i].ld;
      #1;
      chk($sformatf("mux_%0d", i), mar_mux, vt[i].exp_mux);
      tick();
      ld_mar = 1'b0;
      chk($sformatf("mar_%0d", i), mar, vt[i].exp_mar);
    end

    // Read with ready on the third ACCESS cycle.
    run_access(3, 1'b0, en_n, we_n, rdy, to);
    chk("rd_en_cycles", en_n, 3);
    chk("rd_we_cycles", we_n, 0);
    chk("rd_ready", rdy, 1'b1);
    chk("rd_timeout", to, 1'b0);
    chk("rd_done_outs", {mem_en, busy}, 2'b01);
    tick();
    chk("rd_ready_width", {ready, busy}, 2'b00);

    // Write, minimum latency.
    run_access(1, 1'b1, en_n, we_n, rdy, to);
    chk("wr_en_cycles", en_n, 1);
    chk("wr_we_cycles", we_n, 1);
    chk("wr_ready", {rdy, to}, 2'b10);
    tick();

    // No ready: timeout after exactly TIMEOUT cycles.
    run_access(0, 1'b0, en_n, we_n, rdy, to);
    chk("to_en_cycles", en_n, 15);
    chk("to_ready_timeout", {rdy, to}, 2'b11);
    tick();
    chk("to_back_idle", {busy, ready, timeout}, 3'b000);

    // Ready on the final counted cycle completes normally.
    run_access(15, 1'b0, en_n, we_n, rdy, to);
    chk("last_en_cycles", en_n, 15);
    chk("last_ready_timeout", {rdy, to}, 2'b10);
    tick();

    // LdMar during ACCESS is ignored.
    load_mar(16'h00FF);
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_mar = 1'b1; mar_sel = 2'd1; address = 16'h3000;
    tick();
    tick();
    chk("ld_in_access_mar", mar, 16'h00FF);
    chk("ld_in_access_en", mem_en, 1'b1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("ld_in_done_ready", ready, 1'b1);
    tick();
    ld_mar = 1'b0;
    chk("ld_in_done_mar", mar, 16'h00FF);

    // Same-cycle load and start.
    load_mar(16'h1111);
    ld_mar = 1'b1; mar_sel = 2'd1; address = 16'h3000; start = 1'b1;
    tick();
    ld_mar = 1'b0; start = 1'b0;
    chk("ld_start_en", mem_en, 1'b1);
    chk("ld_start_mar", mar, 16'h3000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // Start held while busy does not queue another access.
    start = 1'b1;
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("busy_start_ready", ready, 1'b1);
    tick();
    start = 1'b0;
    en_n = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_en || busy) en_n++;
      tick();
    end
    chk("busy_start_no_extra", en_n, 0);

    // Reset two cycles into ACCESS aborts without a ready pulse.
    load_mar(16'h4444);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", {mem_en, busy, ready, timeout}, 4'b0000);
    chk("rst_mid_mar", mar, 16'h0000);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rst_mid_no_ready", {ready, mem_en}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
